// File: rtl/lut_ff_bank.sv
// lut_ff_bank: bank of registered programmable 4-input LUT channels with clk-domain edge capture
module lut_ff_bank #(
    parameter int          CH          = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] TT_RST      = 16'h0000,
    parameter logic [1:0]  MODE_RST    = 2'b01,
    localparam int         CW          = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] in_a,
    input  logic [CH-1:0] in_b,
    input  logic [CH-1:0] in_c,
    input  logic [CH-1:0] in_d,
    input  logic          clr,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_ch,
    input  logic          cfg_sel,
    input  logic [15:0]   cfg_wdata,
    output logic [CH-1:0] outt,
    output logic [CH-1:0] outt_vld
);
    logic [4*CH-1:0] raw, s;
    logic [CH-1:0]   a_s, b_s, c_s, d_s, d_prev, rise, fall, cap, fval;
    logic [15:0]     tt [CH];
    logic [1:0]      mode [CH];

    assign raw = {in_d, in_c, in_b, in_a};
    assign {d_s, c_s, b_s, a_s} = s;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign s = raw;
        end else begin : g_sync
            logic [4*CH-1:0] st [SYNC_STAGES];
            // shift every raw input bit through the synchroniser chain
            always_ff @(posedge clk or negedge rst)
                if (!rst) st <= '{default: '0};
                else begin
                    st[0] <= raw;
                    for (int k = 1; k < SYNC_STAGES; k++) st[k] <= st[k-1];
                end
            assign s = st[SYNC_STAGES-1];
        end
    endgenerate

    // edge detection, capture qualification and table lookup per channel
    always_comb begin
        rise = d_s & ~d_prev;
        fall = ~d_s & d_prev;
        cap  = '0;
        fval = '0;
        for (int i = 0; i < CH; i++) begin
            cap[i]  = (mode[i] == 2'b00) | (mode[i][0] & rise[i]) | (mode[i][1] & fall[i]);
            fval[i] = tt[i][{d_s[i], c_s[i], b_s[i], a_s[i]}];
        end
    end

    // configuration storage; out-of-range channel numbers match nothing and are dropped
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            tt   <= '{default: TT_RST};
            mode <= '{default: MODE_RST};
        end else begin
            for (int i = 0; i < CH; i++)
                if (cfg_we && cfg_ch == CW'(i)) begin
                    if (cfg_sel) mode[i] <= cfg_wdata[1:0];
                    else tt[i] <= cfg_wdata;
                end
        end

    // previous synchronised d for edge detection, kept across mode changes and clr
    always_ff @(posedge clk or negedge rst)
        if (!rst) d_prev <= '0;
        else d_prev <= d_s;

    // output capture; clr wins over any capture in the same cycle
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            outt     <= '0;
            outt_vld <= '0;
        end else if (clr) begin
            outt     <= '0;
            outt_vld <= '0;
        end else begin
            outt     <= (outt & ~cap) | (fval & cap);
            outt_vld <= cap;
        end
endmodule

// File: tb/tb_lut_ff_bank.sv
// tb_lut_ff_bank: directed self-checking bench for lut_ff_bank
module tb_lut_ff_bank;
    logic       clk = 0, rst = 0, clr = 0;
    logic [3:0] in_a = 0, in_b = 0, in_c = 0, in_d = 0;
    logic       cfg_we = 0, cfg_sel = 0, cfg2_we = 0;
    logic [1:0] cfg_ch = 0;
    logic [15:0] cfg_wdata = 0;
    logic [3:0] outt, outt_vld;
    logic [2:0] in2_a = 0, in2_b = 0, in2_c = 0, in2_d = 0;
    logic [2:0] outt2, outt2_vld;
    int passed = 0, total = 0;
    int p1, p2, cnt;
    logic o1, o2, any;

    lut_ff_bank #(.CH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .clr(clr), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
        .outt(outt), .outt_vld(outt_vld)
    );

    lut_ff_bank #(.CH(3), .SYNC_STAGES(0)) dut2 (
        .clk(clk), .rst(rst), .in_a(in2_a), .in_b(in2_b), .in_c(in2_c), .in_d(in2_d),
        .clr(clr), .cfg_we(cfg2_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
        .outt(outt2), .outt_vld(outt2_vld)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input int ch, input logic sel, input logic [15:0] d);
        cfg_we = 1; cfg_ch = 2'(ch); cfg_sel = sel; cfg_wdata = d;
        tick(1);
        cfg_we = 0;
    endtask

    initial begin
        tick(2);
        rst = 1;
        tick(1);
        chk("rst_outt", 16'(outt), 16'h0);
        chk("rst_vld", 16'(outt_vld), 16'h0);

        for (int i = 0; i < 4; i++) begin
            wr(i, 1, 16'h0000);
            wr(i, 0, 16'hFFFF);
        end
        tick(2);
        chk("all_ones_outt", 16'(outt), 16'hF);
        chk("all_ones_vld", 16'(outt_vld), 16'hF);

        #3 rst = 0;
        #1;
        chk("async_rst_outt", 16'(outt), 16'h0);
        chk("async_rst_vld", 16'(outt_vld), 16'h0);
        @(posedge clk);
        #1 rst = 1;
        in_a = 4'hF; in_b = 4'hF; in_c = 4'hF; in_d = 4'hF;
        tick(2);
        chk("post_rst_early", 16'(outt_vld), 16'h0);
        tick(1);
        chk("post_rst_tt", 16'(outt), 16'h0);
        chk("post_rst_mode_pulse", 16'(outt_vld), 16'hF);
        tick(1);
        chk("post_rst_mode_once", 16'(outt_vld), 16'h0);
        in_a = 0; in_b = 0; in_c = 0; in_d = 0;
        tick(3);

        wr(0, 1, 16'h0000);
        wr(0, 0, 16'h8000);
        in_a = 4'b0001; in_b = 4'b0001; in_c = 4'b0001; in_d = 4'b0001;
        tick(2);
        chk("level_e1", 16'(outt[0]), 16'h0);
        tick(1);
        chk("level_e2", 16'(outt[0]), 16'h1);
        chk("level_vld", 16'(outt_vld[0]), 16'h1);
        in_a = 4'b0000;
        tick(2);
        chk("level_drop_e1", 16'(outt[0]), 16'h1);
        tick(1);
        chk("level_drop_e2", 16'(outt[0]), 16'h0);

        wr(1, 0, 16'hAAAA);
        in_a = 4'b0010;
        tick(3);
        in_d = 4'b0011;
        tick(2);
        chk("rise_early_outt", 16'(outt[1]), 16'h0);
        chk("rise_early_vld", 16'(outt_vld[1]), 16'h0);
        tick(1);
        chk("rise_outt", 16'(outt[1]), 16'h1);
        chk("rise_vld", 16'(outt_vld[1]), 16'h1);
        tick(1);
        chk("rise_vld_single", 16'(outt_vld[1]), 16'h0);
        in_a = 4'b0000;
        any = 0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            any |= outt_vld[1];
        end
        chk("rise_hold_outt", 16'(outt[1]), 16'h1);
        chk("rise_hold_no_pulse", 16'(any), 16'h0);

        wr(2, 0, 16'hAAAA);
        wr(2, 1, 16'h0003);
        in_a = 4'b0100;
        tick(3);
        in_d[2] = 1;
        p1 = 0; p2 = 0; cnt = 0; o1 = 0; o2 = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (outt_vld[2]) begin
                cnt++;
                if (cnt == 1) begin p1 = k; o1 = outt[2]; end
                else begin p2 = k; o2 = outt[2]; end
            end
            if (k == 3) in_a[2] = 0;
            if (k == 5) in_d[2] = 0;
        end
        chk("both_count", 16'(cnt), 16'd2);
        chk("both_first_at", 16'(p1), 16'd3);
        chk("both_spacing", 16'(p2 - p1), 16'd5);
        chk("both_first_val", 16'(o1), 16'h1);
        chk("both_second_val", 16'(o2), 16'h0);

        in_d[1] = 0;
        tick(4);
        in_d[1] = 1;
        tick(2);
        wr(1, 0, 16'h5555);
        chk("coll_old_tt_outt", 16'(outt[1]), 16'h0);
        chk("coll_old_tt_vld", 16'(outt_vld[1]), 16'h1);
        in_d[1] = 0;
        tick(4);
        in_d[1] = 1;
        tick(3);
        chk("coll_new_tt_outt", 16'(outt[1]), 16'h1);
        chk("coll_new_tt_vld", 16'(outt_vld[1]), 16'h1);

        in_d[1] = 0;
        tick(4);
        in_d[1] = 1;
        tick(2);
        clr = 1;
        tick(1);
        clr = 0;
        chk("clr_outt", 16'(outt), 16'h0);
        chk("clr_vld", 16'(outt_vld), 16'h0);
        tick(1);
        chk("clr_level_resume", 16'(outt_vld[0]), 16'h1);
        in_d[1] = 0;
        tick(4);
        in_d[1] = 1;
        tick(3);
        chk("clr_after_outt", 16'(outt[1]), 16'h1);
        chk("clr_after_vld", 16'(outt_vld[1]), 16'h1);

        cfg2_we = 1; cfg_ch = 2'd3; cfg_sel = 0; cfg_wdata = 16'hFFFF;
        tick(1);
        cfg_sel = 1; cfg_wdata = 16'h0000;
        tick(1);
        cfg2_we = 0;
        in2_a = 3'b111; in2_b = 3'b111; in2_c = 3'b111; in2_d = 3'b111;
        tick(1);
        chk("drop_outt", 16'(outt2), 16'h0);
        chk("drop_vld", 16'(outt2_vld), 16'h7);
        tick(1);
        chk("drop_mode", 16'(outt2_vld), 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
